// File: rtl/rtc_access_seq.sv
// rtl/rtc_access_seq.sv - V3023 RTC register access sequencer ahead of the transfer stage.
// Optional readback-after-write verification: define RTC_WRITE_VERIFY_EN.
module rtc_access_seq #(
    parameter int TIMEOUT = 63,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              acc,
    output logic              acc_read,
    input  logic              ad_n,
    input  logic              cs_n,
    input  logic              rd_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in
);
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_read, w_read_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_ad_n_q, r_cs_n_q;
    logic [DATA_W-1:0] r_cap, w_cap_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_acc, w_acc_nxt;
    logic              r_acc_read, w_acc_read_nxt;
    logic [DATA_W-1:0] r_bus_out, w_bus_out_nxt;
    logic              r_bus_oe, w_bus_oe_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;

    logic w_ad_rise, w_cs_rise, w_timeout, w_rd_sample, w_rd_access;

    assign w_ad_rise   = ad_n & ~r_ad_n_q;
    assign w_cs_rise   = cs_n & ~r_cs_n_q;
    assign w_timeout   = (r_cnt == CNT_MAX);
    // rd_n may float; only a solid 0 counts as an active read strobe
    assign w_rd_sample = (cs_n == 1'b0) && (rd_n == 1'b0);

`ifdef RTC_WRITE_VERIFY_EN
    logic r_verify, w_verify_nxt;
    assign w_rd_access = r_read | r_verify;
`else
    assign w_rd_access = r_read;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_read      <= 1'b0;
            r_cnt       <= '0;
            r_ad_n_q    <= 1'b1;
            r_cs_n_q    <= 1'b1;
            r_cap       <= '0;
            r_req_ready <= 1'b1;
            r_acc       <= 1'b0;
            r_acc_read  <= 1'b0;
            r_bus_out   <= '0;
            r_bus_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef RTC_WRITE_VERIFY_EN
            r_verify    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_read      <= w_read_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ad_n_q    <= ad_n;
            r_cs_n_q    <= cs_n;
            r_cap       <= w_cap_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_acc       <= w_acc_nxt;
            r_acc_read  <= w_acc_read_nxt;
            r_bus_out   <= w_bus_out_nxt;
            r_bus_oe    <= w_bus_oe_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`ifdef RTC_WRITE_VERIFY_EN
            r_verify    <= w_verify_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_read_nxt      = r_read;
        w_cnt_nxt       = r_cnt;
        w_cap_nxt       = r_cap;
        w_req_ready_nxt = r_req_ready;
        w_acc_nxt       = r_acc;
        w_acc_read_nxt  = r_acc_read;
        w_bus_out_nxt   = r_bus_out;
        w_bus_oe_nxt    = r_bus_oe;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
`ifdef RTC_WRITE_VERIFY_EN
        w_verify_nxt    = r_verify;
`endif
        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid) begin
                    w_addr_nxt      = req_addr;
                    w_wdata_nxt     = req_wdata;
                    w_read_nxt      = req_read;
                    w_acc_nxt       = 1'b1;
                    w_acc_read_nxt  = req_read;
                    w_bus_out_nxt   = req_addr;
                    w_bus_oe_nxt    = 1'b1;
                    w_cnt_nxt       = '0;
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = S_ADDR;
`ifdef RTC_WRITE_VERIFY_EN
                    w_verify_nxt    = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                if (w_ad_rise) begin
                    w_acc_nxt = 1'b0;
                    // release the bus before transfer can pull rd_n low
                    if (w_rd_access) w_bus_oe_nxt = 1'b0;
                    else             w_bus_out_nxt = r_wdata;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else if (w_timeout) begin
                    w_acc_nxt       = 1'b0;
                    w_bus_oe_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_rd_access && w_rd_sample) w_cap_nxt = bus_in;
                // a completion edge wins over a coincident timeout
                if (w_cs_rise) begin
`ifdef RTC_WRITE_VERIFY_EN
                    if (!r_read && !r_verify) begin
                        w_verify_nxt   = 1'b1;
                        w_acc_nxt      = 1'b1;
                        w_acc_read_nxt = 1'b1;
                        w_bus_out_nxt  = r_addr;
                        w_bus_oe_nxt   = 1'b1;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = S_ADDR;
                    end else begin
                        w_bus_oe_nxt    = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = r_cap;
                        w_rsp_err_nxt   = r_verify && (r_cap != r_wdata);
                        w_state_nxt     = S_DONE;
                    end
`else
                    w_bus_oe_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    if (r_read) w_rsp_rdata_nxt = r_cap;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_DONE;
`endif
                end else if (w_timeout) begin
                    w_acc_nxt       = 1'b0;
                    w_bus_oe_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_req_ready_nxt = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req_ready = r_req_ready;
    assign acc       = r_acc;
    assign acc_read  = r_acc_read;
    assign bus_out   = r_bus_out;
    assign bus_oe    = r_bus_oe;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_rtc_access_seq.sv
// tb/tb_rtc_access_seq.sv - scoreboard bench for rtc_access_seq with a behavioural transfer model.
module tb_rtc_access_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_read = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       acc;
    logic       acc_read;
    logic       ad_n = 1'b1;
    logic       cs_n = 1'b1;
    logic       rd_n = 1'b1;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in = '0;

    rtc_access_seq #(.TIMEOUT(63), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .acc(acc), .acc_read(acc_read),
        .ad_n(ad_n), .cs_n(cs_n), .rd_n(rd_n),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic read; logic [7:0] addr; logic [7:0] wdata;} mreq_t;
    typedef struct packed {logic err; logic [7:0] rdata;} rsp_t;

    mreq_t mq[$];
    rsp_t  sb[$];

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] m_rd_early = 8'h00;
    logic [7:0] m_rd_val = 8'h00;
    int         m_data_len = 4;
    logic       m_chk_data = 1'b1;
    logic       m_busy = 1'b0;
    logic [7:0] last_rd = 8'h00;

    // transfer stage model: address phase, gap, then CS/RD data phase
    initial begin
        mreq_t cur;
        forever begin
            @(negedge clk);
            if (acc && !reset) begin
                m_busy = 1'b1;
                cur = '0;
                n_checks++;
                if (mq.size() == 0) begin
                    n_fail++;
                    $display("FAIL model_queue: acc=1 with no pending access, required none");
                end else begin
                    cur = mq.pop_front();
                    if (acc_read !== cur.read) begin
                        n_fail++;
                        $display("FAIL acc_read: got %b required %b", acc_read, cur.read);
                    end
                end
                ad_n = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    n_checks++;
                    if (bus_oe !== 1'b1 || bus_out !== cur.addr) begin
                        n_fail++;
                        $display("FAIL addr_phase: oe=%b bus_out=%h required oe=1 bus_out=%h", bus_oe, bus_out, cur.addr);
                    end
                end
                ad_n = 1'b1;
                repeat (2) @(negedge clk);
                cs_n = 1'b0;
                if (cur.read) begin
                    rd_n = 1'b0;
                    bus_in = m_rd_early;
                end
                for (int i = 0; i < m_data_len; i++) begin
                    if (cur.read && i >= m_data_len / 2) bus_in = m_rd_val;
                    @(negedge clk);
                    if (m_chk_data) begin
                        n_checks++;
                        if (acc !== 1'b0 || bus_oe !== !cur.read || (!cur.read && bus_out !== cur.wdata)) begin
                            n_fail++;
                            $display("FAIL data_phase: acc=%b oe=%b bus_out=%h required acc=0 oe=%b bus_out=%h",
                                     acc, bus_oe, bus_out, !cur.read, cur.wdata);
                        end
                    end
                end
                cs_n = 1'b1;
                rd_n = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    // response scoreboard and bus contention monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_oe === 1'b1 && rd_n === 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL contention: bus_oe=1 while rd_n=0, required bus_oe=0");
            end
            if (rsp_valid === 1'b1) begin
                rsp_t e;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL rsp: err=%b rdata=%h required err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic rd, input logic [7:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rdata, input logic exp_err);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_read  = rd;
        req_addr  = addr;
        req_wdata = wd;
        while (req_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end else begin
            mq.push_back({rd, addr, wd});
`ifdef RTC_WRITE_VERIFY_EN
            if (!rd) mq.push_back({1'b1, addr, wd});
`endif
            sb.push_back({exp_err, exp_rdata});
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drop: req_ready=%b after accept, required 0", req_ready);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || m_busy || req_ready !== 1'b1) && n < 600) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0 || m_busy || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: pending=%0d busy=%b ready=%b, required 0/0/1", name, sb.size(), m_busy, req_ready);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || acc !== 1'b0 || acc_read !== 1'b0 || bus_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b acc=%b acc_read=%b oe=%b required 1/0/0/0", req_ready, acc, acc_read, bus_oe);
        end
        n_checks++;
        if (bus_out !== 8'h00 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: bus_out=%h rsp_valid=%b err=%b rdata=%h required 00/0/0/00",
                     bus_out, rsp_valid, rsp_err, rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        m_data_len = 4;
        m_rd_early = 8'h45;
        m_rd_val   = 8'h45;
`ifdef RTC_WRITE_VERIFY_EN
        do_req(1'b0, 8'h21, 8'h45, 8'h45, 1'b0);
        last_rd = 8'h45;
`else
        do_req(1'b0, 8'h21, 8'h45, last_rd, 1'b0);
`endif
        wait_idle("write");
    endtask

    task automatic test_read();
        m_data_len = 6;
        m_rd_early = 8'h11;
        m_rd_val   = 8'h59;
        do_req(1'b1, 8'h22, 8'h00, 8'h59, 1'b0);
        last_rd = 8'h59;
        wait_idle("read");
    endtask

    task automatic test_timeout();
        int n = 0;
        m_chk_data = 1'b0;
        m_data_len = 90;
        m_rd_early = 8'hC3;
        m_rd_val   = 8'hC3;
        do_req(1'b1, 8'h30, 8'h00, last_rd, 1'b1);
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || acc !== 1'b0 || bus_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: rsp_valid=%b acc=%b oe=%b required 1/0/0", rsp_valid, acc, bus_oe);
        end
        n_checks++;
        if (n < 60 || n > 80) begin
            n_fail++;
            $display("FAIL timeout_latency: %0d cycles, required 60..80", n);
        end
        wait_idle("timeout");
        m_chk_data = 1'b1;
    endtask

    task automatic test_back_to_back();
        m_data_len = 3;
        m_rd_early = 8'h5A;
        m_rd_val   = 8'h5A;
        do_req(1'b1, 8'h40, 8'h00, 8'h5A, 1'b0);
        req_valid = 1'b1;
        req_read  = 1'b1;
        req_addr  = 8'h77;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ready: req_ready=%b while busy, required 0", req_ready);
            end
        end
        req_valid = 1'b0;
`ifdef RTC_WRITE_VERIFY_EN
        do_req(1'b0, 8'h41, 8'h99, 8'h5A, 1'b1);
`else
        do_req(1'b0, 8'h41, 8'h99, 8'h5A, 1'b0);
`endif
        do_req(1'b1, 8'h42, 8'h00, 8'h5A, 1'b0);
        last_rd = 8'h5A;
        wait_idle("back_to_back");
    endtask

`ifdef RTC_WRITE_VERIFY_EN
    task automatic test_write_verify();
        m_data_len = 4;
        m_rd_early = 8'h7E;
        m_rd_val   = 8'h7E;
        do_req(1'b0, 8'h10, 8'h7F, 8'h7E, 1'b1);
        last_rd = 8'h7E;
        wait_idle("write_verify");
    endtask
`endif

    task automatic test_reset_mid();
        int n = 0;
        m_chk_data = 1'b0;
        m_data_len = 20;
        do_req(1'b0, 8'h50, 8'hAA, 8'h00, 1'b0);
        sb.delete();
        while (cs_n !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_oe: bus_oe=%b in write data phase, required 1", bus_oe);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_oe !== 1'b0 || acc !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: oe=%b acc=%b ready=%b rsp_valid=%b required 0/0/1/0", bus_oe, acc, req_ready, rsp_valid);
        end
        reset = 1'b0;
        last_rd = 8'h00;
        wait_idle("reset_mid");
        mq.delete();
        repeat (5) @(negedge clk);
        m_chk_data = 1'b1;
        m_data_len = 4;
        m_rd_early = 8'h3C;
        m_rd_val   = 8'h3C;
        do_req(1'b1, 8'h51, 8'h00, 8'h3C, 1'b0);
        wait_idle("post_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_to_back();
`ifdef RTC_WRITE_VERIFY_EN
        test_write_verify();
`endif
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
